// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency line memory answering cache refill and writeback requests
module mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    output logic         req_ready,
    output logic         resp_valid,
    output logic         resp_write,
    output logic [127:0] resp_rdata,
    input  logic         resp_ready,
    output logic         busy
);

    localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [3:0]         count;
    logic               lat_write;
    logic [IDX_W-1:0]   lat_idx;
    logic [127:0]       lat_wdata;
    logic [127:0]       lines [DEPTH_LINES];
    logic               fire;
    logic               unused_addr;

    assign unused_addr = ^{req_addr[31:IDX_W+4], req_addr[3:0]};
    assign fire        = (state == WAIT) && (count == 4'd0);

    // Gated by reset so the responder never advertises readiness while held in reset.
    assign req_ready   = (state == IDLE) && !reset;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            lat_write  <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_idx   <= req_addr[IDX_W+3:4];
                        lat_wdata <= req_wdata;
                        count     <= 4'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_write <= lat_write;
                        resp_rdata <= lat_write ? 128'd0 : lines[lat_idx];
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain; an async reset aborts WAIT so fire drops.
    always_ff @(posedge clk) begin
        if (fire && lat_write) begin
            lines[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder at LATENCY 4 and 1
module tb_mem_responder;

    logic         clk;
    logic         rst        [2];
    logic         req_valid  [2];
    logic         req_write  [2];
    logic [31:0]  req_addr   [2];
    logic [127:0] req_wdata  [2];
    logic         req_ready  [2];
    logic         resp_valid [2];
    logic         resp_write [2];
    logic [127:0] resp_rdata [2];
    logic         resp_ready [2];
    logic         busy       [2];

    logic [127:0] model [2][256];
    bit           known [2][256];

    int errors = 0;
    int checks = 0;

    mem_responder #(.LATENCY(4), .DEPTH_LINES(256)) u_lat4 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_write(resp_write[0]), .resp_rdata(resp_rdata[0]),
        .resp_ready(resp_ready[0]), .busy(busy[0])
    );

    mem_responder #(.LATENCY(1), .DEPTH_LINES(256)) u_lat1 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_write(resp_write[1]), .resp_rdata(resp_rdata[1]),
        .resp_ready(resp_ready[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full request/response exchange; called and returns at a falling edge.
    task automatic do_txn(input int sel, input bit wr, input logic [31:0] addr,
                          input logic [127:0] data, input int bp);
        int lat;
        int idx;
        int waited;
        bit chk_data;
        logic [127:0] exp;
        lat = (sel != 0) ? 1 : 4;
        idx = int'((addr >> 4) % 256);
        waited = 0;
        while (!req_ready[sel] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[sel]) begin
            check("ready_timeout", 128'(req_ready[sel]), 128'd1);
            return;
        end
        req_write[sel]  = wr;
        req_addr[sel]   = addr;
        req_wdata[sel]  = data;
        req_valid[sel]  = 1'b1;
        resp_ready[sel] = 1'b0;
        @(posedge clk);
        #1;
        // Keep a conflicting request asserted; it must be ignored until the exchange completes.
        req_write[sel] = ~wr;
        req_addr[sel]  = $urandom;
        req_wdata[sel] = {$urandom, $urandom, $urandom, $urandom};
        if (wr) begin
            exp = 128'd0;
            chk_data = 1'b1;
        end else begin
            exp = model[sel][idx];
            chk_data = known[sel][idx];
        end
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < lat) begin
                check("early_resp_valid", 128'(resp_valid[sel]), 128'd0);
                check("wait_busy", 128'(busy[sel]), 128'd1);
            end else begin
                check("resp_valid_at_latency", 128'(resp_valid[sel]), 128'd1);
                check("resp_write", 128'(resp_write[sel]), 128'(wr));
                if (chk_data) check("resp_rdata", resp_rdata[sel], exp);
            end
        end
        for (int b = 0; b < bp; b++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_resp_valid", 128'(resp_valid[sel]), 128'd1);
            check("bp_req_ready", 128'(req_ready[sel]), 128'd0);
            check("bp_resp_write", 128'(resp_write[sel]), 128'(wr));
            if (chk_data) check("bp_resp_rdata", resp_rdata[sel], exp);
        end
        resp_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[sel]  = 1'b0;
        resp_ready[sel] = 1'b0;
        check("post_hs_resp_valid", 128'(resp_valid[sel]), 128'd0);
        check("post_hs_busy", 128'(busy[sel]), 128'd0);
        check("post_hs_req_ready", 128'(req_ready[sel]), 128'd1);
        if (wr) begin
            model[sel][idx] = data;
            known[sel][idx] = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input int sel, input string tag);
        check({tag, "_req_ready"}, 128'(req_ready[sel]), 128'd0);
        check({tag, "_resp_valid"}, 128'(resp_valid[sel]), 128'd0);
        check({tag, "_resp_write"}, 128'(resp_write[sel]), 128'd0);
        check({tag, "_resp_rdata"}, resp_rdata[sel], 128'd0);
        check({tag, "_busy"}, 128'(busy[sel]), 128'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int idx;
        a = $urandom;
        idx = $urandom_range(0, 8);
        if (idx == 8) idx = 255;
        a[11:4] = 8'(idx);
        return a;
    endfunction

    initial begin
        int accepts;
        int resps;
        logic [127:0] k80;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1;
            req_valid[s] = 1'b0;
            req_write[s] = 1'b0;
            req_addr[s] = '0;
            req_wdata[s] = '0;
            resp_ready[s] = 1'b0;
            for (int i = 0; i < 256; i++) known[s][i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "rst4");
        check_reset_outputs(1, "rst1");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        check("release_req_ready4", 128'(req_ready[0]), 128'd1);
        check("release_req_ready1", 128'(req_ready[1]), 128'd1);
        @(negedge clk);

        // Write, read back through a different byte offset, then address wrap.
        do_txn(0, 1'b1, 32'h0000_0040, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0);
        do_txn(0, 1'b0, 32'h0000_004C, 128'd0, 0);
        do_txn(0, 1'b1, 32'h0000_1040, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 0);
        do_txn(0, 1'b0, 32'h0000_0040, 128'd0, 0);
        do_txn(0, 1'b0, 32'h0000_0040, 128'd0, 5);

        // Reset in WAIT must not store the in-flight write.
        k80 = 128'h80808080_11111111_22222222_33333333;
        do_txn(0, 1'b1, 32'h0000_0080, k80, 0);
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0080;
        req_wdata[0] = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check_reset_outputs(0, "abort_wait");
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        #1 check("abort_release_ready", 128'(req_ready[0]), 128'd1);
        resps = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid[0]) resps++;
        end
        check("abort_no_resp", 128'(resps), 128'd0);
        do_txn(0, 1'b0, 32'h0000_0080, 128'd0, 0);

        // Minimum latency, then reset while a response is pending.
        do_txn(1, 1'b1, 32'h0000_0010, 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF, 0);
        do_txn(1, 1'b0, 32'h0000_0010, 128'd0, 2);
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h0000_0010;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_pending_l1", 128'(resp_valid[1]), 128'd1);
        rst[1] = 1'b1;
        #1;
        check_reset_outputs(1, "drop_resp");
        @(negedge clk);
        rst[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_resp_stays_low", 128'(resp_valid[1]), 128'd0);
        check("drop_resp_idle", 128'(req_ready[1]), 128'd1);

        // Continuous requests with a willing consumer: one accept every three cycles.
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b0;
        req_addr[1]   = 32'h0000_0010;
        resp_ready[1] = 1'b1;
        accepts = 0;
        resps = 0;
        for (int i = 0; i < 30; i++) begin
            if (req_ready[1]) accepts++;
            if (resp_valid[1]) resps++;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid[1]  = 1'b0;
        check("b2b_accepts", 128'(accepts), 128'd10);
        check("b2b_resps", 128'(resps), 128'd10);
        @(posedge clk);
        @(negedge clk);
        resp_ready[1] = 1'b0;
        check("b2b_idle", 128'(busy[1]), 128'd0);

        for (int n = 0; n < 40; n++)
            do_txn(0, 1'($urandom_range(0, 1)), rand_addr(),
                   {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
        for (int n = 0; n < 20; n++)
            do_txn(1, 1'($urandom_range(0, 1)), rand_addr(),
                   {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
